// File: rtl/sc_io_pkg.sv
`timescale 1ns/1ps
// Shared constants for the memory-mapped I/O port unit.
// Word offsets are addr[6:2] inside the I/O region; STATUS bit positions per input port.
// Pure constants: no latency, no backpressure.
package sc_io_pkg;
  localparam logic [4:0] IO_OUT0 = 5'd0;   // byte 0x80
  localparam logic [4:0] IO_OUT1 = 5'd1;   // byte 0x84
  localparam logic [4:0] IO_OUT2 = 5'd2;   // byte 0x88
  localparam logic [4:0] IO_IN0  = 5'd16;  // byte 0xC0
  localparam logic [4:0] IO_IN1  = 5'd17;  // byte 0xC4
  localparam logic [4:0] IO_STAT = 5'd18;  // byte 0xC8

  localparam int STAT_IN0_BIT = 0;
  localparam int STAT_IN1_BIT = 1;
endpackage

// File: rtl/io_sync2.sv
`timescale 1ns/1ps
// Two-flop synchronizer for an asynchronous input bus, plus a prev register for change detection.
// Latency: q follows d two edges after the change; chg is high for the edge after q updates.
// Backpressure: none, free-running every cycle.
// Ports: clock, resetn (async active-low), d (async input), q (synchronized), chg (q != prev).
module io_sync2
  import sc_io_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         chg
);

  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [W-1:0] prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q1   <= '0;
      q2   <= '0;
      prev <= '0;
    end else begin
      q1   <= d;
      q2   <= q1;
      prev <= q2;
    end
  end

  assign q   = q2;
  assign chg = (q2 != prev);

endmodule

// File: rtl/sc_io_port_unit.sv
`timescale 1ns/1ps
// Memory-mapped I/O responder: three RW output ports, two synchronized input ports, read-clear STATUS.
// Latency: stores land and loads return one edge after the strobe cycle; io_sel is combinational.
// Backpressure: none; every strobe completes in one cycle.
// Ports: clock, resetn, addr, wdata, wmem, rmem, in_port0/1 (async), out_port0/1/2, io_read_data, io_sel.
module sc_io_port_unit
  import sc_io_pkg::*;
#(
  parameter int IO_BASE_BIT = 7,
  parameter int WARMUP      = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  input  logic        rmem,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] io_read_data,
  output logic        io_sel
);

  logic [4:0]  offset;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] in0_q;
  logic [31:0] in1_q;
  logic        in0_chg;
  logic        in1_chg;
  logic [1:0]  warm;
  logic [1:0]  status;
  logic [1:0]  stat_set;
  logic        stat_clr;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign io_sel      = addr[IO_BASE_BIT];
  assign offset      = addr[6:2];
  assign wr_en       = wmem & io_sel;
  assign rd_en       = rmem & io_sel;
  assign unused_addr = &{1'b0, addr};

  io_sync2 #(.W(32)) u_sync0 (
    .clock  (clock),
    .resetn (resetn),
    .d      (in_port0),
    .q      (in0_q),
    .chg    (in0_chg)
  );

  io_sync2 #(.W(32)) u_sync1 (
    .clock  (clock),
    .resetn (resetn),
    .d      (in_port1),
    .q      (in1_q),
    .chg    (in1_chg)
  );

  // Output port registers; stores to RO or unmapped offsets fall through.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else if (wr_en) begin
      case (offset)
        IO_OUT0: out_port0 <= wdata;
        IO_OUT1: out_port1 <= wdata;
        IO_OUT2: out_port2 <= wdata;
        default: ;
      endcase
    end
  end

  // Warmup hides the reset-to-input transition that the synchronizers see right after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      warm <= 2'(WARMUP);
    end else if (warm != 2'd0) begin
      warm <= warm - 2'd1;
    end
  end

  always_comb begin
    stat_set               = 2'b00;
    stat_set[STAT_IN0_BIT] = in0_chg & (warm == 2'd0);
    stat_set[STAT_IN1_BIT] = in1_chg & (warm == 2'd0);
  end

  assign stat_clr = rd_en && (offset == IO_STAT);

  // Clear is applied first so a same-cycle set survives the read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status <= 2'b00;
    end else begin
      status <= (stat_clr ? 2'b00 : status) | stat_set;
    end
  end

  // Read mux sees pre-edge register values, so a simultaneous store returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (offset)
      IO_OUT0: rd_mux = out_port0;
      IO_OUT1: rd_mux = out_port1;
      IO_OUT2: rd_mux = out_port2;
      IO_IN0:  rd_mux = in0_q;
      IO_IN1:  rd_mux = in1_q;
      IO_STAT: rd_mux = {30'b0, status};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      io_read_data <= '0;
    end else if (rd_en) begin
      io_read_data <= rd_mux;
    end
  end

endmodule
